// File: rtl/power_sequencer.sv
// Three-stage supply sequencer: staged power-up with settle/timeout timing,
// reverse-order power-down and a latched fault with emergency cut of all enables.
module power_sequencer #(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 17
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_powerOn,
    input  logic       i_S1Good,
    input  logic       i_S2Good,
    input  logic       i_S3Good,
    output logic       o_S1Enable,
    output logic       o_S2Enable,
    output logic       o_S3Enable,
    output logic       o_monitorResetn,
    output logic       o_powerGood,
    output logic       o_busy,
    output logic       o_fault,
    output logic [1:0] o_faultStage,
    output logic       o_faultTimeout
);

    typedef enum logic [3:0] {
        ST_OFF, ST_UP_S1, ST_SET_S1, ST_UP_S2, ST_SET_S2, ST_UP_S3, ST_SET_S3,
        ST_ON, ST_DN_S3, ST_DN_S2, ST_DN_S1, ST_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] C_SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       w_fstage_nxt;
    logic             w_ftimeout_nxt;
    logic [1:0]       w_fail1;
    logic [1:0]       w_fail2;
    logic [1:0]       w_fail3;
    logic             w_settle_done;
    logic             w_timeout;
    logic             w_counting;
    logic             w_s1_en;
    logic             w_s2_en;
    logic             w_s3_en;
    logic             w_busy;

    // Lowest failing stage among the stages enabled so far; 0 means all good.
    assign w_fail1 = !i_S1Good ? 2'd1 : 2'd0;
    assign w_fail2 = !i_S1Good ? 2'd1 : (!i_S2Good ? 2'd2 : 2'd0);
    assign w_fail3 = !i_S1Good ? 2'd1 : (!i_S2Good ? 2'd2 : (!i_S3Good ? 2'd3 : 2'd0));

    assign w_settle_done = (r_cnt == C_SETTLE_LAST);
    assign w_timeout     = (r_cnt == C_TIMEOUT_LAST);
    assign w_counting    = r_state inside {ST_UP_S1, ST_SET_S1, ST_UP_S2, ST_SET_S2,
                                           ST_UP_S3, ST_SET_S3, ST_DN_S3, ST_DN_S2, ST_DN_S1};

    always_comb begin
        w_state_nxt    = r_state;
        w_fstage_nxt   = o_faultStage;
        w_ftimeout_nxt = o_faultTimeout;
        case (r_state)
            ST_OFF: if (i_powerOn) w_state_nxt = ST_UP_S1;
            ST_UP_S1: begin
                if (!i_powerOn)    w_state_nxt = ST_DN_S1;
                else if (i_S1Good) w_state_nxt = ST_SET_S1;
                else if (w_timeout) begin
                    w_state_nxt = ST_FAULT; w_fstage_nxt = 2'd1; w_ftimeout_nxt = 1'b1;
                end
            end
            ST_SET_S1: begin
                if (!i_powerOn) w_state_nxt = ST_DN_S1;
                else if (w_fail1 != 2'd0) begin
                    w_state_nxt = ST_FAULT; w_fstage_nxt = w_fail1; w_ftimeout_nxt = 1'b0;
                end
                else if (w_settle_done) w_state_nxt = ST_UP_S2;
            end
            ST_UP_S2: begin
                if (!i_powerOn)    w_state_nxt = ST_DN_S2;
                else if (i_S2Good) w_state_nxt = ST_SET_S2;
                else if (w_timeout) begin
                    w_state_nxt = ST_FAULT; w_fstage_nxt = 2'd2; w_ftimeout_nxt = 1'b1;
                end
            end
            ST_SET_S2: begin
                if (!i_powerOn) w_state_nxt = ST_DN_S2;
                else if (w_fail2 != 2'd0) begin
                    w_state_nxt = ST_FAULT; w_fstage_nxt = w_fail2; w_ftimeout_nxt = 1'b0;
                end
                else if (w_settle_done) w_state_nxt = ST_UP_S3;
            end
            ST_UP_S3: begin
                if (!i_powerOn)    w_state_nxt = ST_DN_S3;
                else if (i_S3Good) w_state_nxt = ST_SET_S3;
                else if (w_timeout) begin
                    w_state_nxt = ST_FAULT; w_fstage_nxt = 2'd3; w_ftimeout_nxt = 1'b1;
                end
            end
            ST_SET_S3: begin
                if (!i_powerOn) w_state_nxt = ST_DN_S3;
                else if (w_fail3 != 2'd0) begin
                    w_state_nxt = ST_FAULT; w_fstage_nxt = w_fail3; w_ftimeout_nxt = 1'b0;
                end
                else if (w_settle_done) w_state_nxt = ST_ON;
            end
            ST_ON: begin
                if (w_fail3 != 2'd0) begin
                    w_state_nxt = ST_FAULT; w_fstage_nxt = w_fail3; w_ftimeout_nxt = 1'b0;
                end
                else if (!i_powerOn) w_state_nxt = ST_DN_S3;
            end
            ST_DN_S3: if (w_settle_done) w_state_nxt = ST_DN_S2;
            ST_DN_S2: if (w_settle_done) w_state_nxt = ST_DN_S1;
            ST_DN_S1: if (w_settle_done) w_state_nxt = ST_OFF;
            ST_FAULT: begin
                if (!i_powerOn) begin
                    w_state_nxt = ST_OFF; w_fstage_nxt = 2'd0; w_ftimeout_nxt = 1'b0;
                end
            end
            default: w_state_nxt = ST_OFF;
        endcase
    end

    // Outputs are decoded from the next state so they register together with it.
    assign w_s1_en = w_state_nxt inside {ST_UP_S1, ST_SET_S1, ST_UP_S2, ST_SET_S2,
                                         ST_UP_S3, ST_SET_S3, ST_ON, ST_DN_S3, ST_DN_S2};
    assign w_s2_en = w_state_nxt inside {ST_UP_S2, ST_SET_S2, ST_UP_S3, ST_SET_S3,
                                         ST_ON, ST_DN_S3};
    assign w_s3_en = w_state_nxt inside {ST_UP_S3, ST_SET_S3, ST_ON};
    assign w_busy  = w_state_nxt inside {ST_UP_S1, ST_SET_S1, ST_UP_S2, ST_SET_S2,
                                         ST_UP_S3, ST_SET_S3, ST_DN_S3, ST_DN_S2, ST_DN_S1};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state         <= ST_OFF;
            r_cnt           <= '0;
            o_S1Enable      <= 1'b0;
            o_S2Enable      <= 1'b0;
            o_S3Enable      <= 1'b0;
            o_monitorResetn <= 1'b0;
            o_powerGood     <= 1'b0;
            o_busy          <= 1'b0;
            o_fault         <= 1'b0;
            o_faultStage    <= 2'd0;
            o_faultTimeout  <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            if (w_state_nxt != r_state) r_cnt <= '0;
            else if (w_counting)        r_cnt <= r_cnt + CNT_W'(1);
            o_S1Enable      <= w_s1_en;
            o_S2Enable      <= w_s2_en;
            o_S3Enable      <= w_s3_en;
            o_monitorResetn <= (w_state_nxt != ST_OFF);
            o_powerGood     <= (w_state_nxt == ST_ON);
            o_busy          <= w_busy;
            o_fault         <= (w_state_nxt == ST_FAULT);
            o_faultStage    <= w_fstage_nxt;
            o_faultTimeout  <= w_ftimeout_nxt;
        end
    end

endmodule

// File: doc/power_sequencer.md
Name: power_sequencer

Overview:
- Sequences the three supply stages on and off, one stage at a time.
- Drives the regulator enables for stages 1–3 and consumes the S1Good/S2Good/S3Good stage-good outputs from the rail-monitor top level.
- Drives the shared active-low reset of the rail monitors.
- Latches a fault if a stage fails to come up or drops out, and powers down in reverse order on request.

Parameters:
- SETTLE_CYCLES, default 1000: cycles a stage-good must hold before the next stage is enabled; also the gap between stages during power-down. Legal range ≥1.
- TIMEOUT_CYCLES, default 100000: maximum cycles allowed from a stage enable to its stage-good. Legal range ≥2.
- CNT_W, default 17: counter width. Must satisfy 2^CNT_W > max(SETTLE_CYCLES, TIMEOUT_CYCLES).

Ports:
- i_clk, input, 1: system clock.
- i_reset, input, 1: asynchronous reset, active-high.
- i_powerOn, input, 1: level request; 1 = power up, 0 = power down.
- i_S1Good, input, 1: stage 1 all-good.
- i_S2Good, input, 1: stage 2 all-good.
- i_S3Good, input, 1: stage 3 all-good.
- o_S1Enable, output, 1: stage 1 regulator enable.
- o_S2Enable, output, 1: stage 2 regulator enable.
- o_S3Enable, output, 1: stage 3 regulator enable.
- o_monitorResetn, output, 1: active-low reset to all rail monitors.
- o_powerGood, output, 1: all stages up and settled.
- o_busy, output, 1: sequencing in progress (up or down).
- o_fault, output, 1: latched fault.
- o_faultStage, output, 2: failing stage; 0 = none, 1..3 = stage number.
- o_faultTimeout, output, 1: 1 = enable timeout, 0 = good dropout.

Behaviour:
- Moore FSM; all outputs registered and decoded from the state and fault registers. One shared counter `cnt`, cleared on every state change.
- Asynchronous reset:
  - State goes to OFF and `cnt` to 0.
  - All enables 0, o_monitorResetn 0, o_powerGood 0, o_busy 0, o_fault 0, o_faultStage 0, o_faultTimeout 0.
- Enables per state: o_SnEnable = 1 in every state where stage n is enabled or being settled, and in the ON state and the down-wait states that follow it.
- o_monitorResetn: 0 only in OFF. Monitors therefore clear their latched faults when powered off and hold fault indication while in FAULT.
- o_busy: 1 in UP_Sn, SET_Sn and DN_Sn.
- OFF: if i_powerOn is sampled 1, go to UP_S1 on the next edge; otherwise stay.
- UP_Sn (stage n enabled, waiting for good):
  - i_SnGood = 1 → SET_Sn.
  - Else if cnt == TIMEOUT_CYCLES-1 → FAULT, with faultStage = n and faultTimeout = 1.
  - Else cnt++.
- SET_Sn (settling):
  - If any already-enabled stage good (S1..Sn) is 0 → FAULT, with faultStage = the lowest failing stage and faultTimeout = 0.
  - Else if cnt == SETTLE_CYCLES-1 → UP_S(n+1), or ON when n = 3.
  - Else cnt++.
- Power-up priority: in UP_Sn and SET_Sn, i_powerOn = 0 has priority over the transitions above. It sends the FSM to DN_Sn, the highest enabled stage.
- ON:
  - o_powerGood = 1.
  - Dropout check takes priority: any good = 0 → FAULT, with the lowest failing stage and faultTimeout = 0.
  - Else i_powerOn = 0 → DN_S3.
- DN_Sn:
  - Stage n enable is 0; lower stages remain enabled.
  - Wait SETTLE_CYCLES, then go to DN_S(n-1); after DN_S1 go to OFF.
  - Stage-good inputs are ignored. i_powerOn returning to 1 mid-shutdown is ignored until OFF is reached.
- FAULT:
  - All enables are 0 on the entry edge (emergency cut, not sequenced).
  - o_fault = 1; o_faultStage and o_faultTimeout hold the values latched on entry.
  - Exit to OFF only when i_powerOn is sampled 0; the fault registers clear on that transition.
  - A request held at 1 never auto-restarts.
- Fault precedence: when several goods drop in one cycle, report the lowest stage number.
- Counter: never wraps. It is compared for equality and cleared on each transition.
- Latency: enable asserts one cycle after i_powerOn is sampled. The S(n+1) enable asserts SETTLE_CYCLES+1 cycles after i_SnGood is first sampled 1.
- Reset mid-operation forces the reset values immediately, regardless of state.

Test Plan:
- All bench cases use SETTLE_CYCLES = 4 and TIMEOUT_CYCLES = 16.
- Nominal up: i_powerOn = 1, each Good asserted 2 cycles after its enable.
  - Required: enables rise in order S1, S2, S3 with 5-cycle gaps after each good.
  - Required: o_powerGood = 1 and o_busy = 0 in ON; o_monitorResetn = 1 from the first enable onward.
- Timeout: i_powerOn = 1, i_S2Good held at 0.
  - Required: FAULT exactly 16 cycles after S2 enters UP; all enables 0, o_faultStage = 2, o_faultTimeout = 1.
  - Required: fault holds while i_powerOn = 1; i_powerOn = 0 returns to OFF with the fault cleared.
- Dropout in ON: drop i_S1Good and i_S3Good in the same cycle.
  - Required: next edge gives o_faultStage = 1, o_faultTimeout = 0, all enables 0, o_powerGood = 0, o_monitorResetn = 1.
- Orderly down: from ON, i_powerOn = 0.
  - Required: S3Enable falls, then S2Enable 4 cycles later, then S1Enable 4 cycles later; OFF 4 cycles after that, with o_monitorResetn = 0.
- Abort mid-up: i_powerOn = 0 while in SET_S2.
  - Required: DN_S2 → DN_S1 → OFF, S3Enable never asserted, no fault.
- Async reset in ON: i_reset pulse between clock edges.
  - Required: all outputs immediately take their reset values, with no clock edge needed.
